// File: rtl/dac_spi_pkg.sv
// Shared constants, state encoding and frame builder for the MCP4801-style DAC SPI transmitter.
package dac_spi_pkg;

    localparam int         FRAME_BITS  = 16;
    localparam int         PAD_BITS    = 4;
    localparam logic [3:0] DEFAULT_CMD = 4'b0011;
    localparam int         LDAC_WIDTH  = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_SHIFT_LO = 3'd3,
        ST_GAP      = 3'd4,
        ST_LDAC     = 3'd5
    } state_t;

    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0] cmd,
                                                          input logic [7:0] code);
        return {cmd, code, {PAD_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/spi_half_tick.sv
// SCLK half-period timer: reloaded by restart on each FSM state entry, tick marks the last cycle of a phase.
module spi_half_tick
    import dac_spi_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_restart,
    output logic o_tick
);

    localparam int CNT_W = $clog2(CLK_DIV + 1);

    logic [CNT_W-1:0] r_cnt;

    // Loading CLK_DIV-1 makes a phase last exactly CLK_DIV cycles, including CLK_DIV=1.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_restart) begin
            r_cnt <= CNT_W'(CLK_DIV - 1);
        end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_tick = (r_cnt == '0);

endmodule

// File: rtl/dac_spi_tx.sv
// SPI mode-0 master sending {CMD, code, 0000} frames to an 8-bit DAC.
// Optional DAC_LDAC_PULSE_EN adds an ldac_n strobe state after the chip-select gap.
module dac_spi_tx
    import dac_spi_pkg::*;
#(
    parameter int         CLK_DIV  = 2,
    parameter int         CS_HIGH  = 4,
    parameter logic [3:0] CMD_BITS = DEFAULT_CMD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       spi_start,
    input  logic [7:0] voltage,
    output logic       busy,
    output logic       done,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic [2:0] debug_state
`ifdef DAC_LDAC_PULSE_EN
    ,
    output logic       ldac_n
`endif
);

    localparam int AUX_MAX = (CS_HIGH > LDAC_WIDTH) ? CS_HIGH : LDAC_WIDTH;
    localparam int AUX_W   = $clog2(AUX_MAX + 1);

    state_t                  r_state;
    state_t                  w_next_state;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [4:0]              r_bit_cnt;
    logic [AUX_W-1:0]        r_aux_cnt;
    logic                    r_done;
    logic                    w_tick;
    logic                    w_restart;

    assign w_restart = (w_next_state != r_state);

    spi_half_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_half_tick (
        .i_clk     (clk),
        .i_reset   (reset),
        .i_restart (w_restart),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        sclk         = 1'b0;
        cs_n         = 1'b1;
        mosi         = 1'b0;
        busy         = 1'b1;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                if (spi_start) begin
                    w_next_state = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cs_n = 1'b0;
                mosi = r_shift[FRAME_BITS-1];
                if (w_tick) begin
                    w_next_state = ST_SHIFT_HI;
                end
            end
            ST_SHIFT_HI: begin
                cs_n = 1'b0;
                sclk = 1'b1;
                mosi = r_shift[FRAME_BITS-1];
                if (w_tick) begin
                    w_next_state = ST_SHIFT_LO;
                end
            end
            ST_SHIFT_LO: begin
                cs_n = 1'b0;
                mosi = r_shift[FRAME_BITS-1];
                if (w_tick) begin
                    w_next_state = (r_bit_cnt < 5'(FRAME_BITS)) ? ST_SHIFT_HI : ST_GAP;
                end
            end
            ST_GAP: begin
                if (r_aux_cnt == AUX_W'(CS_HIGH - 1)) begin
`ifdef DAC_LDAC_PULSE_EN
                    w_next_state = ST_LDAC;
`else
                    w_next_state = ST_IDLE;
`endif
                end
            end
            ST_LDAC: begin
                if (r_aux_cnt == AUX_W'(LDAC_WIDTH - 1)) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                busy         = 1'b0;
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // The shift happens on leaving SHIFT_HI so the next bit is already on mosi while sclk is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else if (r_state == ST_IDLE && spi_start) begin
            r_shift   <= build_frame(CMD_BITS, voltage);
            r_bit_cnt <= '0;
        end else if (r_state == ST_SHIFT_HI && w_tick) begin
            r_shift   <= {r_shift[FRAME_BITS-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt + 5'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_aux_cnt <= '0;
        end else if (w_restart) begin
            r_aux_cnt <= '0;
        end else if (r_state == ST_GAP || r_state == ST_LDAC) begin
            r_aux_cnt <= r_aux_cnt + AUX_W'(1);
        end
    end

    // Only GAP or LDAC can return to IDLE, so this marks the first IDLE cycle after a full frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_done <= 1'b0;
        end else begin
            r_done <= (r_state != ST_IDLE) && (w_next_state == ST_IDLE);
        end
    end

    assign done        = r_done;
    assign debug_state = r_state;

`ifdef DAC_LDAC_PULSE_EN
    assign ldac_n = (r_state != ST_LDAC);
`endif

endmodule

// File: tb/tb_dac_spi_tx.sv
// Directed bench for dac_spi_tx: frame content, timing, ignored requests, back-to-back and mid-frame reset.
module tb_dac_spi_tx;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       spi_start = 1'b0;
    logic [7:0] voltage = 8'h00;
    logic       busy, done, sclk, mosi, cs_n;
    logic [2:0] debug_state;
`ifdef DAC_LDAC_PULSE_EN
    logic       ldac_n;
    localparam int EXP_BUSY = 72;
    localparam int EXP_GAP  = 7;
`else
    localparam int EXP_BUSY = 70;
    localparam int EXP_GAP  = 5;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    dac_spi_tx dut (
        .clk         (clk),
        .reset       (reset),
        .spi_start   (spi_start),
        .voltage     (voltage),
        .busy        (busy),
        .done        (done),
        .sclk        (sclk),
        .mosi        (mosi),
        .cs_n        (cs_n),
        .debug_state (debug_state)
`ifdef DAC_LDAC_PULSE_EN
        ,
        .ldac_n      (ldac_n)
`endif
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bus monitor (samples on falling clk edge) ----------------
    logic        prev_sclk = 1'b0, prev_cs = 1'b1, prev_busy = 1'b0, prev_ldac = 1'b1;
    logic        hi_bit = 1'b0;
    logic [15:0] cur_frame = '0, last_frame = '0;
    int          cur_rises = 0, last_rises = 0;
    int          cur_cs_low = 0, last_cs_low = 0;
    int          gap_run = 0, last_gap = 0;
    int          busy_run = 0, last_busy = 0;
    int          done_cnt = 0, unstable_cnt = 0, bad_rise_cnt = 0;
    int          ldac_run = 0, last_ldac_len = 0, ldac_offset = 0;
    logic        cur_ldac;

`ifdef DAC_LDAC_PULSE_EN
    assign cur_ldac = ldac_n;
`else
    assign cur_ldac = 1'b1;
`endif

    always @(negedge clk) begin
        if (!cs_n && prev_cs) begin
            last_gap   = gap_run;
            cur_frame  = '0;
            cur_rises  = 0;
            cur_cs_low = 0;
        end
        if (sclk && !prev_sclk) begin
            cur_frame = {cur_frame[14:0], mosi};
            cur_rises++;
            hi_bit = mosi;
            if (cs_n) bad_rise_cnt++;
        end else if (sclk && prev_sclk && mosi !== hi_bit) begin
            unstable_cnt++;
        end
        if (!cs_n) cur_cs_low++;
        if (cs_n && !prev_cs) begin
            last_frame  = cur_frame;
            last_rises  = cur_rises;
            last_cs_low = cur_cs_low;
            gap_run     = 0;
        end
        if (!cur_ldac && prev_ldac) begin
            ldac_offset = gap_run;
            ldac_run    = 0;
        end
        if (!cur_ldac) ldac_run++;
        if (cur_ldac && !prev_ldac) last_ldac_len = ldac_run;
        if (cs_n) gap_run++;
        if (busy && !prev_busy) busy_run = 0;
        if (busy) busy_run++;
        if (!busy && prev_busy) last_busy = busy_run;
        if (done === 1'b1) done_cnt++;
        prev_sclk = sclk;
        prev_cs   = cs_n;
        prev_busy = busy;
        prev_ldac = cur_ldac;
    end

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // ---------------- drivers ----------------
    // Call mid-cycle; the request is seen by the next rising edge.
    task automatic send(input logic [7:0] v, input logic [15:0] exp_frame);
        spi_start = 1'b1;
        voltage   = v;
        exp_q.push_back(exp_frame);
        @(posedge clk);
        #1;
        spi_start = 1'b0;
    endtask

    // Returns mid-way through the done cycle, so a follow-up send lands in it.
    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            #1;
            if (done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic check_frame(input string tag);
        logic [15:0] exp;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 16'hxxxx;
        check({tag, "_frame"}, 32'(last_frame), 32'(exp));
        check({tag, "_rises"}, 32'(last_rises), 32'd16);
    endtask

    // ---------------- stimulus ----------------
    int d0;

    initial begin
        #2;
        check("rst_cs_n",  32'(cs_n),        32'd1);
        check("rst_sclk",  32'(sclk),        32'd0);
        check("rst_mosi",  32'(mosi),        32'd0);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_state", 32'(debug_state), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Basic frame
        d0 = done_cnt;
        send(8'hA5, 16'h3A50);
        check("basic_busy_next", 32'(busy), 32'd1);
        check("basic_setup_state", 32'(debug_state), 32'd1);
        wait_done("basic");
        check("basic_busy_in_done", 32'(busy), 32'd0);
        check_frame("basic");
        check("basic_busy_len", 32'(last_busy), 32'(EXP_BUSY));
        check("basic_cs_low",   32'(last_cs_low), 32'd66);
`ifdef DAC_LDAC_PULSE_EN
        check("basic_ldac_idle", 32'(ldac_n), 32'd1);
`endif
        @(negedge clk);
        #1;
        check("basic_done_width", 32'(done), 32'd0);
        check("basic_done_count", 32'(done_cnt - d0), 32'd1);
        repeat (3) @(posedge clk);
        #1;

        // Boundary codes, second one back-to-back, then 5A in the done cycle
        send(8'h00, 16'h3000);
        wait_done("zero");
        check_frame("zero");
        repeat (2) @(posedge clk);
        #1;
        send(8'hFF, 16'h3FF0);
        wait_done("ones");
        check_frame("ones");
        send(8'h5A, 16'h35A0);
        check("b2b_state", 32'(debug_state), 32'd1);
        check("b2b_busy",  32'(busy), 32'd1);
        wait_done("b2b");
        check_frame("b2b");
        check("b2b_gap", 32'(last_gap), 32'(EXP_GAP));
        repeat (3) @(posedge clk);
        #1;

        // Request while busy is dropped
        d0 = done_cnt;
        send(8'hC3, 16'h3C30);
        repeat (18) @(posedge clk);
        #1;
        spi_start = 1'b1;
        voltage   = 8'h11;
        @(posedge clk);
        #1;
        spi_start = 1'b0;
        check("ign_busy", 32'(busy), 32'd1);
        wait_done("ign");
        check_frame("ign");
        repeat (10) @(posedge clk);
        #1;
        check("ign_not_queued", 32'(busy), 32'd0);
        check("ign_done_count", 32'(done_cnt - d0), 32'd1);

        // Reset after the 7th sclk rising edge
        d0 = done_cnt;
        send(8'h77, 16'h3770);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            #1;
            if (cur_rises == 7) break;
        end
        check("mid_rises_reached", 32'(cur_rises), 32'd7);
        reset = 1'b1;
        #1;
        check("mid_cs_n",  32'(cs_n),        32'd1);
        check("mid_sclk",  32'(sclk),        32'd0);
        check("mid_busy",  32'(busy),        32'd0);
        check("mid_state", 32'(debug_state), 32'd0);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);
        send(8'h3C, 16'h33C0);
        wait_done("post_rst");
        check_frame("post_rst");
        check("post_rst_busy_len", 32'(last_busy), 32'(EXP_BUSY));

`ifdef DAC_LDAC_PULSE_EN
        repeat (2) @(posedge clk);
        #1;
        send(8'h80, 16'h3800);
        wait_done("ldac");
        check_frame("ldac");
        check("ldac_len",    32'(last_ldac_len), 32'd2);
        check("ldac_offset", 32'(ldac_offset),   32'd4);
        check("ldac_busy",   32'(last_busy),     32'd72);
`endif

        check("mosi_stable_hi", 32'(unstable_cnt), 32'd0);
        check("sclk_only_cs_low", 32'(bad_rise_cnt), 32'd0);
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dac_spi_tx.md
Name: dac_spi_tx

Overview:
- SPI master that takes each `voltage` word and its one-cycle `spi_start` request from the diode ramp counter.
- Serialises the word as a 16-bit frame to an external 8-bit DAC (MCP4801-style), so the counter's requests become actual analog output.
- Sits between the counter and the board pins; runs on the system `clk`.
- Accepts one request at a time and reports busy/done back to the control logic.

Parameters:
- CLK_DIV, 2: clk cycles per SCLK half-period; minimum 1.
- CS_HIGH, 4: minimum clk cycles `cs_n` stays high between frames; minimum 1.
- CMD_BITS, 4'b0011: 4 config bits sent first (A/B=0, BUF=0, GA=1x, SHDN=1 active).

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- spi_start  in  1  one-cycle request; sampled only when busy=0
- voltage  in  8  DAC code; captured on the accepted spi_start cycle
- busy  out  1  high from the cycle after acceptance until the frame and CS gap finish
- done  out  1  one-cycle pulse at frame completion
- sclk  out  1  SPI clock, mode 0 (idle low, DAC samples on rising edge)
- mosi  out  1  serial data, MSB first, changes only while sclk is low
- cs_n  out  1  active-low chip select
- debug_state  out  3  current FSM state encoding

Behaviour:
- Reset (async, immediate): state=IDLE, busy=0, done=0, sclk=0, mosi=0, cs_n=1, counters=0. Applies mid-frame as well; the aborted frame is never completed and done is not pulsed.
- Frame: {CMD_BITS, voltage[7:0], 4'b0000}, 16 bits, MSB first; held in a 16-bit shift register.
- States (debug_state encoding): IDLE=0, SETUP=1, SHIFT_HI=2, SHIFT_LO=3, GAP=4.
- IDLE
  - cs_n=1, sclk=0, busy=0.
  - On spi_start=1: load the shift register, clear the divide and bit counters, move to SETUP next cycle.
- SETUP
  - cs_n=0, sclk=0, mosi=frame[15], busy=1.
  - Lasts CLK_DIV cycles, then SHIFT_HI.
- SHIFT_HI
  - sclk=1 for CLK_DIV cycles.
  - On exit: bit_cnt increments and the shift register shifts left (zero fill).
  - Next state is SHIFT_LO.
- SHIFT_LO
  - sclk=0 for CLK_DIV cycles; mosi shows the new MSB from the first cycle of this state.
  - On exit: SHIFT_HI if bit_cnt<16, else GAP.
- GAP
  - cs_n=1, sclk=0, mosi=0, busy=1 for CS_HIGH cycles, then IDLE.
  - done=1 for exactly the first IDLE cycle.
- Timing
  - busy is high for exactly CLK_DIV*(1+2*16)+CS_HIGH cycles; defaults give 70.
  - Exactly 16 sclk rising edges per frame, all while cs_n=0.
- Request handling
  - spi_start while busy=1 is ignored: not queued, and voltage is not resampled.
  - spi_start in the done cycle (busy=0) is accepted normally, giving back-to-back frames.
  - voltage changing mid-frame has no effect.
- Width rules
  - Divide counter is $clog2(CLK_DIV+1) bits; bit counter is 5 bits.
  - All compares are on exact terminal counts; no wrap-around is reachable.

Optional Feature:
- Macro: DAC_LDAC_PULSE_EN.
- When defined:
  - Adds output port ldac_n (1 bit, reset value 1).
  - Adds state LDAC=5 between GAP and IDLE; ldac_n=0 for exactly 2 clk cycles.
  - busy covers LDAC, and done pulses after LDAC ends; defaults give busy high for 72 cycles.
- When undefined:
  - No ldac_n port; the DAC latches on the cs_n rising edge.
  - GAP goes directly to IDLE.

Decomposition:
- Package dac_spi_pkg:
  - state encoding constants (IDLE..LDAC);
  - FRAME_BITS=16, PAD_BITS=4, DEFAULT_CMD=4'b0011, LDAC_WIDTH=2.
- One sub-module, spi_half_tick:
  - a CLK_DIV down-counter that raises a one-cycle `tick` at each phase end;
  - reloaded by `restart` from the FSM on every state entry.
- The FSM and shift register stay in dac_spi_tx.

Test Plan:
- Basic frame: reset, then voltage=8'hA5 with a spi_start pulse -> 16 bits sampled on sclk rising edges equal 16'h3A50; busy high 70 cycles; one done pulse; cs_n low for 66 cycles.
- Boundary codes: voltage=8'h00 and 8'hFF -> frames 16'h3000 and 16'h3FF0; mosi stable during every sclk-high phase.
- Request while busy: spi_start at cycle 20 of a frame with voltage=8'h11 -> ignored, frame content unchanged, only one done.
- Back-to-back: spi_start in the done cycle with voltage=8'h5A -> second frame 16'h35A0 starts next cycle; cs_n high for ≥4 cycles between frames.
- Reset mid-frame: reset asserted after the 7th sclk rising edge -> cs_n=1, sclk=0, busy=0 within the same cycle; no done; the next request gives a clean full frame.
- DAC_LDAC_PULSE_EN defined: voltage=8'h80 -> ldac_n low exactly 2 cycles after cs_n rises plus the 4-cycle gap; done follows; busy high 72 cycles.
